// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared widths and word/address types for the data memory
package data_mem_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] dm_word_t;
  typedef logic [ADDR_W-1:0] dm_addr_t;

endpackage

// File: rtl/data_mem_if.sv
// rtl/data_mem_if.sv - write/read port bundle between the datapath and the data memory
interface data_mem_if;
  import data_mem_pkg::*;

  dm_word_t dmWrDat;
  dm_word_t dmReDat;
  dm_addr_t dmWrDat_addr;
  dm_addr_t dmReDat_addr;
  logic     dmWrite;

  // The datapath drives addresses, data and enable; the memory returns read data.
  modport master (
    output dmWrDat,
    output dmWrDat_addr,
    output dmReDat_addr,
    output dmWrite,
    input  dmReDat
  );

  modport slave (
    input  dmWrDat,
    input  dmWrDat_addr,
    input  dmReDat_addr,
    input  dmWrite,
    output dmReDat
  );

endinterface

// File: rtl/data_mem.sv
// rtl/data_mem.sv - 1024x16 data memory, clocked write, combinational read, full synchronous clear
module data_mem
  import data_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  data_mem_if.slave  dm
);

  dm_word_t mem [DEPTH];

  // Reset clears every word and takes priority over a write in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i[ADDR_W-1:0]] <= '0;
      end
    end else if (dm.dmWrite) begin
      mem[dm.dmWrDat_addr] <= dm.dmWrDat;
    end
  end

  // No bypass from write data: a same-address read shows the old word until the edge.
  assign dm.dmReDat = mem[dm.dmReDat_addr];

endmodule

// File: tb/tb_data_mem.sv
// tb/tb_data_mem.sv - directed self-checking bench for data_mem
module tb_data_mem;
  import data_mem_pkg::*;

  logic clk;
  logic rst_n;
  int   vecCount;
  int   missCount;

  data_mem_if dif ();

  data_mem dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dm    (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic edgeWait();
    @(posedge clk);
    #1;
  endtask

  task automatic setRd(input dm_addr_t a);
    dif.dmReDat_addr = a;
    #1;
  endtask

  task automatic writeWord(input dm_addr_t a, input dm_word_t d);
    dif.dmWrDat_addr = a;
    dif.dmWrDat      = d;
    dif.dmWrite      = 1'b1;
    edgeWait();
    dif.dmWrite      = 1'b0;
  endtask

  task automatic test_reset();
    dm_addr_t addrs [3];
    addrs = '{10'd0, 10'd1, 10'd1023};
    rst_n = 1'b0;
    edgeWait();
    rst_n = 1'b1;
    foreach (addrs[k]) begin
      setRd(addrs[k]);
      vecCount++;
      if (dif.dmReDat !== 16'd0) begin
        $display("FAIL reset_state addr %0d: got %h expected %h", addrs[k], dif.dmReDat, 16'd0);
        missCount++;
      end
    end
    foreach (addrs[k]) writeWord(addrs[k], 16'hFFFF);
    foreach (addrs[k]) begin
      setRd(addrs[k]);
      vecCount++;
      if (dif.dmReDat !== 16'hFFFF) begin
        $display("FAIL pre_clear_write addr %0d: got %h expected %h", addrs[k], dif.dmReDat, 16'hFFFF);
        missCount++;
      end
    end
    rst_n = 1'b0;
    edgeWait();
    rst_n = 1'b1;
    foreach (addrs[k]) begin
      setRd(addrs[k]);
      vecCount++;
      if (dif.dmReDat !== 16'd0) begin
        $display("FAIL reset_clear addr %0d: got %h expected %h", addrs[k], dif.dmReDat, 16'd0);
        missCount++;
      end
    end
  endtask

  task automatic test_seq_writes();
    dm_addr_t wa [4];
    dm_word_t wd [4];
    dm_word_t exp [3];
    wa  = '{10'd0, 10'd1, 10'd2, 10'd2};
    wd  = '{16'd47, 16'd47, 16'd47, 16'd74};
    exp = '{16'd47, 16'd47, 16'd74};
    setRd(10'd2);
    dif.dmWrite = 1'b1;
    for (int k = 0; k < 4; k++) begin
      dif.dmWrDat_addr = wa[k];
      dif.dmWrDat      = wd[k];
      edgeWait();
      if (k == 2) begin
        vecCount++;
        if (dif.dmReDat !== 16'd47) begin
          $display("FAIL seq_mid addr 2: got %0d expected %0d", dif.dmReDat, 47);
          missCount++;
        end
      end
    end
    dif.dmWrite = 1'b0;
    for (int k = 0; k < 3; k++) begin
      setRd(k[ADDR_W-1:0]);
      vecCount++;
      if (dif.dmReDat !== exp[k]) begin
        $display("FAIL seq_writes addr %0d: got %0d expected %0d", k, dif.dmReDat, exp[k]);
        missCount++;
      end
    end
  endtask

  task automatic test_write_disabled();
    dif.dmWrite      = 1'b0;
    dif.dmWrDat_addr = 10'd5;
    dif.dmWrDat      = 16'd999;
    setRd(10'd5);
    repeat (4) edgeWait();
    vecCount++;
    if (dif.dmReDat !== 16'd0) begin
      $display("FAIL write_disabled addr 5: got %0d expected %0d", dif.dmReDat, 0);
      missCount++;
    end
  endtask

  task automatic test_same_addr();
    writeWord(10'd7, 16'd3);
    setRd(10'd7);
    dif.dmWrDat_addr = 10'd7;
    dif.dmWrDat      = 16'd9;
    dif.dmWrite      = 1'b1;
    #1;
    vecCount++;
    if (dif.dmReDat !== 16'd3) begin
      $display("FAIL same_addr_before: got %0d expected %0d", dif.dmReDat, 3);
      missCount++;
    end
    edgeWait();
    vecCount++;
    if (dif.dmReDat !== 16'd9) begin
      $display("FAIL same_addr_after: got %0d expected %0d", dif.dmReDat, 9);
      missCount++;
    end
    dif.dmWrite = 1'b0;
  endtask

  task automatic test_boundary();
    setRd(10'd0);
    writeWord(10'd1023, 16'hA5A5);
    vecCount++;
    if (dif.dmReDat !== 16'd47) begin
      $display("FAIL boundary_indep addr 0: got %h expected %h", dif.dmReDat, 16'd47);
      missCount++;
    end
    setRd(10'd1023);
    vecCount++;
    if (dif.dmReDat !== 16'hA5A5) begin
      $display("FAIL boundary_top addr 1023: got %h expected %h", dif.dmReDat, 16'hA5A5);
      missCount++;
    end
    setRd(10'd0);
    vecCount++;
    if (dif.dmReDat !== 16'd47) begin
      $display("FAIL boundary_addr0 addr 0: got %h expected %h", dif.dmReDat, 16'd47);
      missCount++;
    end
  endtask

  task automatic test_reset_collision();
    dm_addr_t addrs [3];
    addrs = '{10'd4, 10'd0, 10'd1023};
    writeWord(10'd4, 16'd55);
    rst_n            = 1'b0;
    dif.dmWrite      = 1'b1;
    dif.dmWrDat_addr = 10'd4;
    dif.dmWrDat      = 16'd123;
    setRd(10'd4);
    edgeWait();
    vecCount++;
    if (dif.dmReDat !== 16'd0) begin
      $display("FAIL reset_collision addr 4: got %0d expected %0d", dif.dmReDat, 0);
      missCount++;
    end
    edgeWait();
    rst_n       = 1'b1;
    dif.dmWrite = 1'b0;
    foreach (addrs[k]) begin
      setRd(addrs[k]);
      vecCount++;
      if (dif.dmReDat !== 16'd0) begin
        $display("FAIL reset_held addr %0d: got %0d expected %0d", addrs[k], dif.dmReDat, 0);
        missCount++;
      end
    end
  endtask

  initial begin
    vecCount         = 0;
    missCount        = 0;
    rst_n            = 1'b1;
    dif.dmWrite      = 1'b0;
    dif.dmWrDat      = '0;
    dif.dmWrDat_addr = '0;
    dif.dmReDat_addr = '0;
    edgeWait();
    test_reset();
    test_seq_writes();
    test_write_disabled();
    test_same_addr();
    test_boundary();
    test_reset_collision();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
